// File: rtl/usart_tx_sched.sv
// ---------------------------------------------------------------------------
// usart_tx_sched
//
// Transmit scheduler for the USART TX path. Two byte sources are arbitrated
// round-robin. The winning byte is latched onto PISO_D, and the external
// parallel-in/serial-out frame shifter is then sequenced with one load strobe
// followed by one shift-enable strobe per bit period, for FRAME_BITS bit
// periods (start bit, 8 data bits, STOP_BITS stop bits).
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit period (2..65535)
//   STOP_BITS    : number of stop bits (1 or 2)
//
// Ports
//   CLK        in   system clock, rising edge
//   CLR        in   asynchronous active-low reset
//   EN         in   allows new grants; a running frame always completes
//   REQ0/REQ1  in   source request, held until the matching ACK
//   DATA0/1    in   source byte, stable while its REQ is high
//   ACK0/ACK1  out  one-cycle accept pulse for the granted source
//   PISO_D     out  latched byte, constant for the whole frame
//   PISO_LOAD  out  one-cycle load strobe to the PISO
//   PISO_CE    out  one-cycle shift enable, once per bit period
//   GRANT_ID   out  source of the current or last frame
//   BUSY       out  frame in progress (LOAD or SHIFT)
//   DONE       out  one-cycle pulse on the final shift enable
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module usart_tx_sched #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       EN,
    input  logic       REQ0,
    input  logic [7:0] DATA0,
    input  logic       REQ1,
    input  logic [7:0] DATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [7:0] PISO_D,
    output logic       PISO_LOAD,
    output logic       PISO_CE,
    output logic       GRANT_ID,
    output logic       BUSY,
    output logic       DONE
);

    localparam int FRAME_BITS = 9 + STOP_BITS;
    localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              pri, pri_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [3:0]        bit_cnt, bit_nxt;
    logic              winner;

    logic       ack0_nxt, ack1_nxt, load_nxt, ce_nxt, done_nxt, gid_nxt;
    logic [7:0] piso_d_nxt;

    // Round-robin pick: a lone requester always wins; on a tie the pointer
    // decides which source is favoured.
    function automatic logic arbitrate(input logic r0, input logic r1,
                                       input logic p);
        if (r0 && r1) return p;
        return r1;
    endfunction

    // --------------------------------------------------------------------
    // State and control registers
    // --------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            pri      <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            pri      <= pri_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    // --------------------------------------------------------------------
    // Next-state and next-output logic
    // --------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        pri_nxt    = pri;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_cnt;
        winner     = 1'b0;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        load_nxt   = 1'b0;
        ce_nxt     = 1'b0;
        done_nxt   = 1'b0;
        gid_nxt    = GRANT_ID;
        piso_d_nxt = PISO_D;

        unique case (state)
            IDLE: begin
                if (EN && (REQ0 || REQ1)) begin
                    winner     = arbitrate(REQ0, REQ1, pri);
                    state_nxt  = LOAD;
                    pri_nxt    = ~winner;
                    gid_nxt    = winner;
                    piso_d_nxt = winner ? DATA1 : DATA0;
                    ack0_nxt   = ~winner;
                    ack1_nxt   = winner;
                    load_nxt   = 1'b1;
                    baud_nxt   = '0;
                    bit_nxt    = '0;
                end
            end

            // The baud counter already runs during the load cycle, so the
            // first shift enable lands exactly one bit period after the load.
            LOAD: begin
                state_nxt = SHIFT;
                baud_nxt  = baud_cnt + BAUD_W'(1);
            end

            SHIFT: begin
                // DONE is high in the cycle of the last shift enable; the
                // frame is released on the following edge.
                if (DONE) begin
                    state_nxt = IDLE;
                end else if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    bit_nxt  = bit_cnt + 4'd1;
                    ce_nxt   = 1'b1;
                    done_nxt = (bit_cnt == BIT_LAST);
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // --------------------------------------------------------------------
    // Registered outputs
    // --------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            PISO_LOAD <= 1'b0;
            PISO_CE   <= 1'b0;
            DONE      <= 1'b0;
            GRANT_ID  <= 1'b0;
            PISO_D    <= 8'h00;
        end else begin
            ACK0      <= ack0_nxt;
            ACK1      <= ack1_nxt;
            PISO_LOAD <= load_nxt;
            PISO_CE   <= ce_nxt;
            DONE      <= done_nxt;
            GRANT_ID  <= gid_nxt;
            PISO_D    <= piso_d_nxt;
        end
    end

    // BUSY is a decode of the state flop only.
    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_usart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_usart_tx_sched
//
// Two instances: index 0 runs CLKS_PER_BIT=4/STOP_BITS=1, index 1 runs
// CLKS_PER_BIT=3/STOP_BITS=2. Stimulus pushes the expected frame for each
// request into a per-instance queue; a monitor on the falling edge pops an
// entry on every PISO_LOAD and follows the frame through a PISO model.
// ---------------------------------------------------------------------------
module tb_usart_tx_sched;

    typedef struct {
        logic        gid;
        logic [7:0]  data;
        logic [10:0] bits;   // bit i = serial bit emitted on shift enable i+1
    } frame_t;

    logic clk;
    logic clr_n;
    logic [1:0] en, req0, req1;
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];

    logic [1:0] ack0_o, ack1_o, load_o, ce_o, gid_o, busy_o, done_o;
    logic [7:0] pd_o [2];

    int n_cmp  = 0;
    int n_fail = 0;

    frame_t qa[$];
    frame_t qb[$];

    // Monitor state, one slot per instance
    bit          active   [2];
    bit          busy_chk [2];
    int          cyc      [2];
    int          ld_cyc   [2];
    int          ce_cnt   [2];
    int          ack0_cnt [2];
    int          ack1_cnt [2];
    int          frames   [2];
    logic [10:0] sr       [2];
    logic [10:0] got_bits [2];
    logic [10:0] exp_bits [2];

    usart_tx_sched #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .CLK(clk), .CLR(clr_n), .EN(en[0]),
        .REQ0(req0[0]), .DATA0(d0[0]), .REQ1(req1[0]), .DATA1(d1[0]),
        .ACK0(ack0_o[0]), .ACK1(ack1_o[0]), .PISO_D(pd_o[0]),
        .PISO_LOAD(load_o[0]), .PISO_CE(ce_o[0]), .GRANT_ID(gid_o[0]),
        .BUSY(busy_o[0]), .DONE(done_o[0])
    );

    usart_tx_sched #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
        .CLK(clk), .CLR(clr_n), .EN(en[1]),
        .REQ0(req0[1]), .DATA0(d0[1]), .REQ1(req1[1]), .DATA1(d1[1]),
        .ACK0(ack0_o[1]), .ACK1(ack1_o[1]), .PISO_D(pd_o[1]),
        .PISO_LOAD(load_o[1]), .PISO_CE(ce_o[1]), .GRANT_ID(gid_o[1]),
        .BUSY(busy_o[1]), .DONE(done_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int cpb_of(input int id);
        return (id == 0) ? 4 : 3;
    endfunction

    function automatic int fb_of(input int id);
        return (id == 0) ? 10 : 11;
    endfunction

    // Expected serial order: start 0, data LSB first, stop bit(s) 1.
    function automatic logic [10:0] fbits(input int id, input logic [7:0] d);
        return (id == 0) ? {1'b0, 1'b1, d, 1'b0} : {1'b1, 1'b1, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic gid, input logic [7:0] d,
                        input logic [10:0] bits);
        frame_t e;
        e.gid  = gid;
        e.data = d;
        e.bits = bits;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic mon_step(input int id);
        frame_t e;
        bit     have;
        if (!clr_n) begin
            active[id]   = 0;
            busy_chk[id] = 0;
            return;
        end
        cyc[id]++;
        if (busy_chk[id]) begin
            check("busy_fall_after_done", 32'(busy_o[id]), 32'd0);
            busy_chk[id] = 0;
        end
        if (load_o[id]) begin
            if (ack0_o[id]) ack0_cnt[id]++;
            if (ack1_o[id]) ack1_cnt[id]++;
            have = (id == 0) ? (qa.size() != 0) : (qb.size() != 0);
            if (!have) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                check("grant_id", 32'(gid_o[id]), 32'(e.gid));
                check("piso_d", 32'(pd_o[id]), 32'(e.data));
                check("ack_onehot", 32'({ack1_o[id], ack0_o[id]}),
                      e.gid ? 32'd2 : 32'd1);
                check("ce_with_load", 32'(ce_o[id]), 32'd0);
                check("busy_in_load", 32'(busy_o[id]), 32'd1);
                exp_bits[id] = e.bits;
            end
            sr[id]       = {2'b11, pd_o[id], 1'b0};
            got_bits[id] = '0;
            active[id]   = 1;
            ld_cyc[id]   = cyc[id];
            ce_cnt[id]   = 0;
        end else if (ack0_o[id] || ack1_o[id]) begin
            check("ack_without_load", 32'd1, 32'd0);
        end
        if (ce_o[id]) begin
            if (!active[id]) begin
                check("ce_outside_frame", 32'd1, 32'd0);
            end else begin
                ce_cnt[id]++;
                check("ce_timing", 32'(cyc[id]), 32'(ld_cyc[id] + ce_cnt[id] * cpb_of(id)));
                check("busy_in_shift", 32'(busy_o[id]), 32'd1);
                if (ce_cnt[id] <= 11) got_bits[id][ce_cnt[id]-1] = sr[id][0];
                sr[id] = sr[id] >> 1;
                check("done_on_last_ce", 32'(done_o[id]), 32'(ce_cnt[id] == fb_of(id)));
                if (done_o[id]) begin
                    check("serial_bits", 32'(got_bits[id]), 32'(exp_bits[id]));
                    frames[id]++;
                    active[id]   = 0;
                    busy_chk[id] = 1;
                end
            end
        end else if (done_o[id]) begin
            check("done_without_ce", 32'd1, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int id, input int src);
        int lat = 0;
        bit seen = 0;
        while (!seen && lat < 100) begin
            tick();
            lat++;
            seen = (src == 0) ? ack0_o[id] : ack1_o[id];
        end
        check("req_to_ack_latency", 32'(lat), 32'd1);
        if (src == 0) req0[id] = 1'b0;
        else          req1[id] = 1'b0;
    endtask

    task automatic req_single(input int id, input int src, input logic [7:0] d,
                              input logic [10:0] bits);
        if (src == 0) begin req0[id] = 1'b1; d0[id] = d; end
        else          begin req1[id] = 1'b1; d1[id] = d; end
        push(id, 1'(src), d, bits);
        wait_ack(id, src);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy_o[id] && n < 200);
        if (busy_o[id]) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_zero(input int id);
        check("rst_piso_d", 32'(pd_o[id]), 32'd0);
        check("rst_ack0", 32'(ack0_o[id]), 32'd0);
        check("rst_ack1", 32'(ack1_o[id]), 32'd0);
        check("rst_load", 32'(load_o[id]), 32'd0);
        check("rst_ce", 32'(ce_o[id]), 32'd0);
        check("rst_grant_id", 32'(gid_o[id]), 32'd0);
        check("rst_busy", 32'(busy_o[id]), 32'd0);
        check("rst_done", 32'(done_o[id]), 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int k, l0, l1, acks, a0_base, a1_base, fr_base, nce;
        bit seen;

        clr_n = 1'b0;
        en    = 2'b11;
        req0  = 2'b00;
        req1  = 2'b00;
        d0[0] = 8'h00; d0[1] = 8'h00;
        d1[0] = 8'h00; d1[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; busy_chk[i] = 0; cyc[i] = 0; ld_cyc[i] = 0;
            ce_cnt[i] = 0; ack0_cnt[i] = 0; ack1_cnt[i] = 0; frames[i] = 0;
            sr[i] = '0; got_bits[i] = '0; exp_bits[i] = '0;
        end
        tick();
        tick();
        check_zero(0);
        check_zero(1);
        clr_n = 1'b1;
        tick();

        // Single request, 0x0B -> serial 0,1,1,0,1,0,0,0,0,1
        req_single(0, 0, 8'h0B, 11'b01000010110);
        wait_idle(0);
        check("single_frames_done", 32'(frames[0]), 32'd1);

        // Simultaneous requests from reset
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        tick();
        req0[0] = 1'b1; d0[0] = 8'hA5;
        req1[0] = 1'b1; d1[0] = 8'h3C;
        push(0, 1'b0, 8'hA5, fbits(0, 8'hA5));
        push(0, 1'b1, 8'h3C, fbits(0, 8'h3C));
        k = 0; l0 = -1; l1 = -1;
        while (l1 < 0 && k < 200) begin
            tick();
            k++;
            if (ack0_o[0]) begin req0[0] = 1'b0; l0 = k; end
            if (ack1_o[0]) begin req1[0] = 1'b0; l1 = k; end
        end
        check("sim_first_ack_cycle", 32'(l0), 32'd1);
        check("sim_load_spacing", 32'(l1 - l0), 32'd42);
        wait_idle(0);

        // Fairness over six frames with both sources holding REQ
        a0_base = ack0_cnt[0];
        a1_base = ack1_cnt[0];
        req0[0] = 1'b1; d0[0] = 8'h5A;
        req1[0] = 1'b1; d1[0] = 8'hC3;
        for (int i = 0; i < 6; i++)
            push(0, 1'(i % 2), (i % 2) ? 8'hC3 : 8'h5A,
                 fbits(0, (i % 2) ? 8'hC3 : 8'h5A));
        acks = 0; k = 0;
        while (acks < 6 && k < 600) begin
            tick();
            k++;
            if (ack0_o[0] || ack1_o[0]) acks++;
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        check("fair_ack_total", 32'(acks), 32'd6);
        wait_idle(0);
        check("fair_ack0_count", 32'(ack0_cnt[0] - a0_base), 32'd3);
        check("fair_ack1_count", 32'(ack1_cnt[0] - a1_base), 32'd3);

        // EN gating: nothing granted while EN=0
        en[0] = 1'b0;
        req1[0] = 1'b1; d1[0] = 8'h77;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack1_o[0] || busy_o[0]) seen = 1;
        end
        check("en_low_blocks_grant", 32'(seen), 32'd0);
        push(0, 1'b1, 8'h77, fbits(0, 8'h77));
        en[0] = 1'b1;
        wait_ack(0, 1);
        wait_idle(0);

        // EN dropped mid-frame: frame still completes
        fr_base = frames[0];
        req_single(0, 0, 8'hE1, fbits(0, 8'hE1));
        tick();
        tick();
        en[0] = 1'b0;
        wait_idle(0);
        check("en_drop_frame_done", 32'(frames[0] - fr_base), 32'd1);
        en[0] = 1'b1;

        // Reset after the 4th shift enable, then a fresh frame
        fr_base = frames[0];
        a0_base = ack0_cnt[0];
        req_single(0, 0, 8'h96, fbits(0, 8'h96));
        nce = 0; k = 0;
        while (nce < 4 && k < 100) begin
            tick();
            k++;
            if (ce_o[0]) nce++;
        end
        check("reset_ce_count_reached", 32'(nce), 32'd4);
        #2;
        clr_n = 1'b0;
        #1;
        check_zero(0);
        @(posedge clk);
        #1;
        req0[0] = 1'b1; d0[0] = 8'h69;
        push(0, 1'b0, 8'h69, fbits(0, 8'h69));
        clr_n = 1'b1;
        wait_ack(0, 0);
        wait_idle(0);
        check("reset_frames_done", 32'(frames[0] - fr_base), 32'd1);
        check("reset_ack0_count", 32'(ack0_cnt[0] - a0_base), 32'd2);

        // Two stop bits at 3 clocks per bit
        req_single(1, 0, 8'hC5, fbits(1, 8'hC5));
        wait_idle(1);
        check("stop2_frames_done", 32'(frames[1]), 32'd1);

        tick();
        check("queue_a_empty", 32'(qa.size()), 32'd0);
        check("queue_b_empty", 32'(qb.size()), 32'd0);
        check("total_frames_a", 32'(frames[0]), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
